// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and stall signals of the unified-memory port arbiter.
// slave = arbiter side, master = requesters plus memory model side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall_if;
    logic              stall_mem;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between IF fetch and MEM load/store with fixed wait states.
// Optional stall counters enabled by defining MEM_PORT_ARB_PERF_EN.
//
// state  | meaning
// IDLE   | no access in flight
// BUSY_I | fetch access in flight
// BUSY_D | data access in flight
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MEM_PORT_ARB_PERF_EN
    output logic [31:0] perf_if_stall,
    output logic [31:0] perf_d_stall,
`endif
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              start_i, start_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        start_i     = 1'b0;
        start_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.d_req) begin
                    start_d = 1'b1;
                end else if (bus.if_req) begin
                    start_i = 1'b1;
                end
            end
            BUSY_I: begin
                if (cnt_q == 4'd0) begin
                    if_rdata_d = bus.mem_rdata;
                    if_ready_d = 1'b1;
                    // Only the other side may win here, so neither requester starves.
                    if (bus.d_req) begin
                        start_d = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        mem_en_d = 1'b0;
                        mem_we_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            BUSY_D: begin
                if (cnt_q == 4'd0) begin
                    d_rdata_d = bus.mem_rdata;
                    d_ready_d = 1'b1;
                    if (bus.if_req) begin
                        start_i = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        mem_en_d = 1'b0;
                        mem_we_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase

        if (start_d) begin
            state_d     = BUSY_D;
            cnt_d       = CNT_LOAD;
            mem_en_d    = 1'b1;
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
        end else if (start_i) begin
            state_d     = BUSY_I;
            cnt_d       = CNT_LOAD;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.stall_if  = bus.if_req & ~if_ready_q;
    assign bus.stall_mem = bus.d_req & ~d_ready_q;

`ifdef MEM_PORT_ARB_PERF_EN
    logic [31:0] perf_if_stall_q, perf_if_stall_d;
    logic [31:0] perf_d_stall_q, perf_d_stall_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_if_stall_q <= '0;
            perf_d_stall_q  <= '0;
        end else begin
            perf_if_stall_q <= perf_if_stall_d;
            perf_d_stall_q  <= perf_d_stall_d;
        end
    end

    // Saturating: a full counter stays at all-ones instead of wrapping.
    always_comb begin
        perf_if_stall_d = perf_if_stall_q;
        perf_d_stall_d  = perf_d_stall_q;
        if (bus.stall_if && (perf_if_stall_q != 32'hFFFF_FFFF)) begin
            perf_if_stall_d = perf_if_stall_q + 32'd1;
        end
        if (bus.stall_mem && (perf_d_stall_q != 32'hFFFF_FFFF)) begin
            perf_d_stall_d = perf_d_stall_q + 32'd1;
        end
    end

    assign perf_if_stall = perf_if_stall_q;
    assign perf_d_stall  = perf_d_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed timing scenarios plus randomized
// concurrent fetch/data traffic checked against a word-array memory reference.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic        is_load;
        logic [31:0] data;
    } d_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus   ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1  ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus15 ();

`ifdef MEM_PORT_ARB_PERF_EN
    logic [31:0] perf_if, perf_d, pi1, pd1, pi15, pd15;
`endif

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
`ifdef MEM_PORT_ARB_PERF_EN
        .perf_if_stall(perf_if), .perf_d_stall(perf_d),
`endif
        .bus(bus)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .rst(rst),
`ifdef MEM_PORT_ARB_PERF_EN
        .perf_if_stall(pi1), .perf_d_stall(pd1),
`endif
        .bus(bus1)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(15)) dut_w15 (
        .clk(clk), .rst(rst),
`ifdef MEM_PORT_ARB_PERF_EN
        .perf_if_stall(pi15), .perf_d_stall(pd15),
`endif
        .bus(bus15)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem    [0:255];
    logic [31:0] shadow [0:255];
    logic [31:0] exp_if [$];
    d_exp_t      exp_d  [$];
    int          owners [$];
    bit          rec_owners = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_if(input logic [31:0] addr);
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        exp_if.push_back(shadow[addr[9:2]]);
    endtask

    task automatic issue_d(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        d_exp_t e;
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wd;
        e.is_load   = ~we;
        if (we) begin
            shadow[addr[9:2]] = wd;
            e.data = wd;
        end else begin
            e.data = shadow[addr[9:2]];
        end
        exp_d.push_back(e);
    endtask

    function automatic logic [31:0] rand_if_addr();
        logic [7:0] w;
        w = 8'($urandom_range(0, 63));
        return {22'd0, w, 2'b00};
    endfunction

    function automatic logic [31:0] rand_d_addr();
        logic [7:0] w;
        w = 8'($urandom_range(64, 123));
        return {22'd0, w, 2'b00};
    endfunction

    task automatic finish_reqs();
        int n;
        n = 0;
        while ((bus.if_req || bus.d_req) && n < 100) begin
            tick();
            if (bus.if_ready) bus.if_req = 1'b0;
            if (bus.d_ready)  bus.d_req  = 1'b0;
            n++;
        end
        if (n >= 100) chk("drain_timeout", 32'(n), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #4 rst = 1'b0;
    endtask

    // Memory model: writes land at clock edges, read data is presented mid-cycle.
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end

    always @(negedge clk) begin
        bus.mem_rdata   = mem[bus.mem_addr[9:2]];
        bus1.mem_rdata  = mem[bus1.mem_addr[9:2]];
        bus15.mem_rdata = mem[bus15.mem_addr[9:2]];
    end

    // Monitor: pops the scoreboard whenever the DUT presents a ready pulse.
    always @(negedge clk) begin
        if (bus.if_ready || bus.d_ready)
            chk("ready_exclusive", {31'd0, bus.if_ready & bus.d_ready}, 32'd0);
        if (bus.if_ready) begin
            if (rec_owners) owners.push_back(2);
            if (exp_if.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL if_unexpected_ready actual=1 required=0");
            end else begin
                chk("if_rdata", bus.if_rdata, exp_if.pop_front());
            end
        end
        if (bus.d_ready) begin
            if (rec_owners) owners.push_back(1);
            if (exp_d.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d_unexpected_ready actual=1 required=0");
            end else begin
                d_exp_t e;
                e = exp_d.pop_front();
                if (e.is_load) chk("d_rdata", bus.d_rdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
            shadow[i] = mem[i];
        end
        mem[4]     = 32'h8C01_0004;
        shadow[4]  = 32'h8C01_0004;
        mem[16]    = 32'h1234_5678;
        shadow[16] = 32'h1234_5678;

        bus.if_req = 1'b0;  bus.if_addr = '0;  bus.d_req = 1'b0;  bus.d_we = 1'b0;
        bus.d_addr = '0;    bus.d_wdata = '0;
        bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
        bus1.d_addr = '0;   bus1.d_wdata = '0;
        bus15.if_req = 1'b0; bus15.if_addr = '0; bus15.d_req = 1'b0; bus15.d_we = 1'b0;
        bus15.d_addr = '0;   bus15.d_wdata = '0;

        // Reset state
        #12;
        chk("rst_mem_en",   {31'd0, bus.mem_en},   32'd0);
        chk("rst_mem_we",   {31'd0, bus.mem_we},   32'd0);
        chk("rst_if_ready", {31'd0, bus.if_ready}, 32'd0);
        chk("rst_d_ready",  {31'd0, bus.d_ready},  32'd0);
        chk("rst_mem_addr", bus.mem_addr,  32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_if_rdata", bus.if_rdata,  32'd0);
        chk("rst_d_rdata",  bus.d_rdata,   32'd0);
        #11 rst = 1'b0;

        // Fetch only
        tick();
        issue_if(32'h10);
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) begin
                tick();
                if (bus.if_ready) bus.if_req = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("t1_mem_en_c%0d", k),   {31'd0, bus.mem_en},   {31'd0, k == 1 || k == 2});
            chk($sformatf("t1_if_ready_c%0d", k), {31'd0, bus.if_ready}, {31'd0, k == 3});
            chk($sformatf("t1_stall_if_c%0d", k), {31'd0, bus.stall_if}, {31'd0, k <= 2});
            if (k == 1 || k == 2) begin
                chk("t1_mem_addr", bus.mem_addr, 32'h10);
                chk("t1_mem_we",   {31'd0, bus.mem_we}, 32'd0);
            end
            if (k == 3) chk("t1_if_rdata", bus.if_rdata, 32'h8C01_0004);
        end
        tick();
        @(negedge clk);
        chk("t1_if_rdata_hold", bus.if_rdata, 32'h8C01_0004);

        // Both requests together: data first, fetch back-to-back
        pulse_reset();
        tick();
        issue_if(32'h20);
        issue_d(1'b1, 32'h100, 32'hDEAD_BEEF);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) begin
                tick();
                if (bus.if_ready) bus.if_req = 1'b0;
                if (bus.d_ready)  bus.d_req  = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("t2_mem_we_c%0d", k),    {31'd0, bus.mem_we},    {31'd0, k == 1 || k == 2});
            chk($sformatf("t2_mem_en_c%0d", k),    {31'd0, bus.mem_en},    {31'd0, k >= 1 && k <= 4});
            chk($sformatf("t2_d_ready_c%0d", k),   {31'd0, bus.d_ready},   {31'd0, k == 3});
            chk($sformatf("t2_if_ready_c%0d", k),  {31'd0, bus.if_ready},  {31'd0, k == 5});
            chk($sformatf("t2_stall_mem_c%0d", k), {31'd0, bus.stall_mem}, {31'd0, k <= 2});
            chk($sformatf("t2_stall_if_c%0d", k),  {31'd0, bus.stall_if},  {31'd0, k <= 4});
            if (k == 1) begin
                chk("t2_mem_addr_d",  bus.mem_addr,  32'h100);
                chk("t2_mem_wdata_d", bus.mem_wdata, 32'hDEAD_BEEF);
            end
            if (k == 3 || k == 4) chk("t2_mem_addr_i", bus.mem_addr, 32'h20);
        end
`ifdef MEM_PORT_ARB_PERF_EN
        chk("t6_perf_d_stall",  perf_d,  32'd3);
        chk("t6_perf_if_stall", perf_if, 32'd5);
        tick();
        force dut.perf_d_stall_q = 32'hFFFF_FFFE;
        issue_d(1'b0, 32'h104, 32'd0);
        @(negedge clk);
        release dut.perf_d_stall_q;
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("t6_perf_d_saturate", perf_d, 32'hFFFF_FFFF);
        finish_reqs();
`endif

        // Loads at three different wait-state settings
        tick();
        issue_d(1'b0, 32'h40, 32'd0);
        bus1.d_req  = 1'b1; bus1.d_we  = 1'b0; bus1.d_addr  = 32'h40;
        bus15.d_req = 1'b1; bus15.d_we = 1'b0; bus15.d_addr = 32'h40;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) begin
                tick();
                if (bus.d_ready)   bus.d_req   = 1'b0;
                if (bus1.d_ready)  bus1.d_req  = 1'b0;
                if (bus15.d_ready) bus15.d_req = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("t4_w2_ready_c%0d", k),  {31'd0, bus.d_ready},   {31'd0, k == 3});
            chk($sformatf("t4_w1_ready_c%0d", k),  {31'd0, bus1.d_ready},  {31'd0, k == 2});
            chk($sformatf("t4_w15_ready_c%0d", k), {31'd0, bus15.d_ready}, {31'd0, k == 16});
            if (k == 3)  chk("t4_w2_rdata",  bus.d_rdata,   32'h1234_5678);
            if (k == 2)  chk("t4_w1_rdata",  bus1.d_rdata,  32'h1234_5678);
            if (k == 16) chk("t4_w15_rdata", bus15.d_rdata, 32'h1234_5678);
        end

        // Continuous requests from both sides must alternate
        tick();
        rec_owners = 1'b1;
        issue_d(1'($urandom_range(0, 1)), rand_d_addr(), $urandom);
        issue_if(rand_if_addr());
        for (int c = 0; c < 80 && (bus.if_req || bus.d_req); c++) begin
            tick();
            if (bus.if_ready) begin
                if (c < 20) issue_if(rand_if_addr());
                else bus.if_req = 1'b0;
            end
            if (bus.d_ready) begin
                if (c < 20) issue_d(1'($urandom_range(0, 1)), rand_d_addr(), $urandom);
                else bus.d_req = 1'b0;
            end
        end
        @(negedge clk);
        #1 rec_owners = 1'b0;
        chk("t3_grant_count_ge8", {31'd0, owners.size() >= 8}, 32'd1);
        if (owners.size() > 0) chk("t3_first_owner_d", 32'(owners[0]), 32'd1);
        for (int i = 1; i < owners.size(); i++)
            chk($sformatf("t3_alternate_%0d", i), {31'd0, owners[i] == owners[i-1]}, 32'd0);

        // Randomized concurrent traffic
        fork
            begin
                for (int n = 0; n < 30; n++) begin
                    int w;
                    repeat ($urandom_range(0, 3)) tick();
                    issue_if(rand_if_addr());
                    w = 0;
                    do begin
                        tick();
                        w++;
                    end while (!bus.if_ready && w < 64);
                    if (w >= 64) chk("rand_if_timeout", 32'(w), 32'd0);
                    bus.if_req = 1'b0;
                end
            end
            begin
                for (int n = 0; n < 30; n++) begin
                    int w;
                    repeat ($urandom_range(0, 3)) tick();
                    issue_d(1'($urandom_range(0, 1)), rand_d_addr(), $urandom);
                    w = 0;
                    do begin
                        tick();
                        w++;
                    end while (!bus.d_ready && w < 64);
                    if (w >= 64) chk("rand_d_timeout", 32'(w), 32'd0);
                    bus.d_req = 1'b0;
                end
            end
        join
        repeat (4) tick();
        chk("exp_if_drained", 32'(exp_if.size()), 32'd0);
        chk("exp_d_drained",  32'(exp_d.size()),  32'd0);

        // Asynchronous reset during an in-flight store
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h1F0; bus.d_wdata = 32'hCAFE_F00D;
        tick();
        @(negedge clk);
        chk("t5_mem_en_busy", {31'd0, bus.mem_en}, 32'd1);
        chk("t5_mem_we_busy", {31'd0, bus.mem_we}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_mem_en_abort", {31'd0, bus.mem_en}, 32'd0);
        chk("t5_mem_we_abort", {31'd0, bus.mem_we}, 32'd0);
        bus.d_req = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("t5_no_ready_%0d", k), {31'd0, bus.d_ready}, 32'd0);
        end
        tick();
        issue_d(1'b0, 32'h100, 32'd0);
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) begin
                tick();
                if (bus.d_ready) bus.d_req = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("t5_fresh_ready_c%0d", k), {31'd0, bus.d_ready}, {31'd0, k == 3});
        end
        repeat (2) tick();
        chk("final_exp_d_drained", 32'(exp_d.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences a single-ported unified memory shared by two requesters in the 5-stage MIPS pipeline.
  - The IF-stage instruction fetch is one requester.
  - The MEM-stage data load/store is the other.
- Grants one access at a time, inserts fixed wait states for the memory latency, and returns read data to the requester.
- Exports per-stage stall signals; the hazard logic maps these onto pcWrite/ifidWrite and pipeline-register freezes.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits
WAIT_CYCLES, 2, memory access duration in cycles (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
if_req  input  1  fetch request; held high until if_ready
if_addr  input  ADDR_W  fetch address; stable while if_req is high
if_rdata  output  DATA_W  fetched instruction; valid while if_ready is high
if_ready  output  1  one-cycle completion pulse for the fetch
d_req  input  1  data request; held high until d_ready
d_we  input  1  1 = store, 0 = load; stable while d_req is high
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_rdata  output  DATA_W  load data; valid while d_ready is high
d_ready  output  1  one-cycle completion pulse for the data access
mem_en  output  1  memory access active
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data; valid in the last cycle of an access
stall_if  output  1  if_req & ~if_ready (combinational)
stall_mem  output  1  d_req & ~d_ready (combinational)

Behaviour:
- Clock and reset: one clock clk; reset rst is asynchronous and active-high.
- Reset values: FSM = IDLE; cnt = 0; owner = none. mem_en, mem_we, if_ready and d_ready are 0. mem_addr, mem_wdata, if_rdata and d_rdata are 0.
- FSM states:
  - IDLE: no access in flight.
  - BUSY_I: fetch access in flight.
  - BUSY_D: data access in flight.
- IDLE transitions at the clock edge:
  - d_req high → BUSY_D. Data has priority because it belongs to the older instruction.
  - Else if_req high → BUSY_I.
  - Else stay in IDLE.
- On entering BUSY_x:
  - Register mem_en = 1, mem_addr and mem_wdata from the winning requester.
  - mem_we = d_we for BUSY_D, 0 for BUSY_I.
  - Load cnt = WAIT_CYCLES - 1.
- Memory outputs are held constant for all WAIT_CYCLES cycles of the access.
- In BUSY_x, cnt decrements by one per cycle. On the edge where cnt == 0:
  - Capture mem_rdata into the owner's rdata register. A store also captures it; the value is don't-care but deterministic.
  - Pulse the owner's ready output for exactly the next cycle.
- Next state at completion:
  - If the other requester's req is high → go directly to its BUSY state (back-to-back, no idle bubble).
  - Else → IDLE; mem_en and mem_we return to 0.
- The just-served requester is never re-granted at its own completion edge. A req still high in its ready cycle is treated as a new request and is sampled by IDLE or at the next completion edge. This guarantees alternation: neither side starves under continuous requests.
- Latency: from req asserted in cycle 0 (arbiter idle) to ready high in cycle WAIT_CYCLES + 1.
- Requester rules:
  - Dropping req before ready is illegal; the arbiter completes the access regardless.
  - if_rdata and d_rdata hold their last value after the ready pulse.
- if_ready and d_ready are never high in the same cycle.
- Asynchronous reset mid-access: the FSM returns to IDLE immediately and mem_we/mem_en drop at once. No ready pulse is issued for the aborted access. Memory contents at the address of an aborted store are undefined.

Optional Feature:
- Macro: MEM_PORT_ARB_PERF_EN.
- When defined:
  - Adds outputs perf_if_stall[31:0] and perf_d_stall[31:0].
  - Each increments in every cycle its stall_if / stall_mem output is high.
  - Both saturate at 0xFFFFFFFF and clear to 0 on rst.
- When undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
1. WAIT_CYCLES = 2, fetch only: if_req = 1, if_addr = 0x10 in cycle 0; memory returns 0x8C010004 → mem_en high in cycles 1-2 with mem_addr = 0x10, mem_we = 0; if_ready high in cycle 3 only; if_rdata = 0x8C010004; stall_if high in cycles 0-2.
2. Both requests in cycle 0 (if_addr = 0x20; d_req store d_addr = 0x100, d_wdata = 0xDEADBEEF) → data served first: mem_we = 1 in cycles 1-2 and d_ready in cycle 3. Fetch starts in cycle 3 with no bubble, mem_addr = 0x20, and if_ready in cycle 5.
3. Continuous if_req and d_req for 20 cycles → grants strictly alternate D, I, D, I; no two consecutive ready pulses go to the same requester.
4. Load: d_req = 1, d_we = 0, d_addr = 0x40; memory holds 0x12345678 → d_rdata = 0x12345678 with d_ready in cycle WAIT_CYCLES + 1. Repeat with WAIT_CYCLES = 1 (ready in cycle 2) and WAIT_CYCLES = 15 (ready in cycle 16).
5. rst asserted asynchronously mid-cycle during BUSY_D (store in flight) → mem_we and mem_en fall before the next clock edge; no d_ready pulse. After rst is released, a fresh d_req completes normally.
6. With MEM_PORT_ARB_PERF_EN defined, rerun scenario 2 → perf_d_stall = 3 and perf_if_stall = 5 at the end. Force a counter to 0xFFFFFFFE, then stall two more cycles → the counter holds at 0xFFFFFFFF.
